// File: rtl/fp2fix_conv.sv
// fp2fix_conv: IEEE-754 single -> signed fixed-point (OUT_W bits, FRAC_W fractional), saturating, NaN-flagged.
// Latency 3 cycles, throughput 1/cycle; all three stages advance together when !out_valid || out_ready.
// Backpressure: in_ready = advance; every stage holds while the output is stalled (no bubble collapsing).
//
// Ports:
//    clk, rst                 rising-edge clock, synchronous active-high reset
//    in_data/in_valid/in_ready    float input with valid/ready handshake
//    out_data/out_valid/out_ready fixed-point result with valid/ready handshake
//    out_sat, out_nan         result clipped to range (incl. +/-Inf) / input was NaN (data 0)
// Build option: define FP2FIX_RNE_EN for round-to-nearest-even; default rounds ties away from zero.
module fp2fix_conv #(
   parameter int OUT_W  = 16,
   parameter int FRAC_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_sat,
   output logic             out_nan
);

   // k = e - 127 + FRAC_W - 23, folded into one constant offset
   localparam logic signed [9:0] K_OFF = 10'(FRAC_W - 150);
   // The significand's leading 1 lands at bit 23+k; it overflows OUT_W bits exactly when k >= OUT_W-23
   localparam logic signed [9:0] OVF_K = 10'(OUT_W - 23);
   localparam logic [OUT_W:0]    MAXP  = {2'b00, {(OUT_W-1){1'b1}}};
   localparam logic [OUT_W:0]    MINM  = {2'b01, {(OUT_W-1){1'b0}}};
   localparam logic [OUT_W-1:0]  MAX_POS = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic [OUT_W-1:0]  MIN_NEG = {1'b1, {(OUT_W-1){1'b0}}};

   logic adv;
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   // ---------------- stage 1: unpack / classify ----------------
   logic [7:0]        exp_c;
   logic [22:0]       mant_c;
   logic signed [9:0] k_c;

   assign exp_c  = in_data[30:23];
   assign mant_c = in_data[22:0];
   assign k_c    = $signed({2'b00, exp_c}) + K_OFF;

   logic              v1, s1, z1, inf1, nan1;
   logic [23:0]       sig1;
   logic signed [9:0] k1;

   always_ff @(posedge clk) begin
      if (rst) begin
         v1 <= 1'b0;
      end else if (adv) begin
         v1   <= in_valid;
         s1   <= in_data[31];
         z1   <= (exp_c == 8'd0);
         inf1 <= (exp_c == 8'hFF) && (mant_c == 23'd0);
         nan1 <= (exp_c == 8'hFF) && (mant_c != 23'd0);
         sig1 <= {1'b1, mant_c};
         k1   <= k_c;
      end
   end

   // ---------------- stage 2: shift ----------------
   logic [63:0]      lsh;
   logic [72:0]      rsh;
   logic [9:0]       nshift;
   logic             ovf_c, g_c, st_c;
   logic [OUT_W-1:0] mag_c;

   assign nshift = 10'(-k1);
   assign lsh    = {40'd0, sig1} << k1[5:0];
   // 40 zero bits below the significand capture guard and sticky for shifts up to 25
   assign rsh    = {9'd0, sig1, 40'd0} >> nshift[4:0];
   assign ovf_c  = (k1 >= OVF_K);

   always_comb begin
      mag_c = '0;
      g_c   = 1'b0;
      st_c  = 1'b0;
      if (!k1[9]) begin
         mag_c = lsh[OUT_W-1:0];
      end else if (nshift > 10'd25) begin
         // everything shifts below the guard position
         st_c = 1'b1;
      end else begin
         mag_c = rsh[40 +: OUT_W];
         g_c   = rsh[39];
         st_c  = |rsh[38:0];
      end
   end

   logic             unused_bits;
`ifdef FP2FIX_RNE_EN
   assign unused_bits = ^{lsh[63:OUT_W], rsh[72:40+OUT_W]};
`else
   assign unused_bits = ^{lsh[63:OUT_W], rsh[72:40+OUT_W], st_c};
`endif

   logic             v2, s2, z2, inf2, nan2, ovf2, g2;
   logic [OUT_W-1:0] mag2;
`ifdef FP2FIX_RNE_EN
   logic             st2;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         v2 <= 1'b0;
      end else if (adv) begin
         v2   <= v1;
         s2   <= s1;
         z2   <= z1;
         inf2 <= inf1;
         nan2 <= nan1;
         ovf2 <= ovf_c;
         mag2 <= mag_c;
         g2   <= g_c;
`ifdef FP2FIX_RNE_EN
         st2  <= st_c;
`endif
      end
   end

   // ---------------- stage 3: round / saturate / sign ----------------
   logic             inc;
   logic [OUT_W:0]   sum;
   logic [OUT_W-1:0] res_d;
   logic             res_sat, res_nan;

`ifdef FP2FIX_RNE_EN
   assign inc = g2 && (st2 || mag2[0]);
`else
   assign inc = g2;
`endif
   assign sum = {1'b0, mag2} + (OUT_W+1)'(inc);

   always_comb begin
      res_d   = '0;
      res_sat = 1'b0;
      res_nan = 1'b0;
      if (nan2) begin
         res_nan = 1'b1;
      end else if (z2) begin
         // zero/denormal, either sign: result stays 0
         res_d = '0;
      end else if (inf2 || ovf2 || (!s2 && sum > MAXP) || (s2 && sum > MINM)) begin
         res_sat = 1'b1;
         res_d   = s2 ? MIN_NEG : MAX_POS;
      end else if (s2) begin
         res_d = -sum[OUT_W-1:0];
      end else begin
         res_d = sum[OUT_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sat   <= 1'b0;
         out_nan   <= 1'b0;
      end else if (adv) begin
         out_valid <= v2;
         out_data  <= res_d;
         out_sat   <= res_sat;
         out_nan   <= res_nan;
      end
   end

endmodule

// File: tb/tb_fp2fix_conv.sv
// Testbench for fp2fix_conv: real-arithmetic reference model with scoreboard,
// directed corner values, backpressure, mid-stream reset and randomized traffic.
module tb_fp2fix_conv;

   localparam int OUT_W  = 16;
   localparam int FRAC_W = 8;
   localparam logic [OUT_W-1:0] MAXV = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic [OUT_W-1:0] MINV = {1'b1, {(OUT_W-1){1'b0}}};

   logic             clk = 1'b0;
   logic             rst;
   logic [31:0]      in_data;
   logic             in_valid;
   logic             in_ready;
   logic [OUT_W-1:0] out_data;
   logic             out_valid;
   logic             out_ready;
   logic             out_sat;
   logic             out_nan;

   always #5 clk = ~clk;

   fp2fix_conv #(.OUT_W(OUT_W), .FRAC_W(FRAC_W)) dut (
      .clk(clk), .rst(rst),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_sat(out_sat), .out_nan(out_nan)
   );

   typedef struct {
      logic [OUT_W-1:0] d;
      logic             sat;
      logic             nan;
      int               cyc;
   } exp_t;

   exp_t             exp_q[$];
   int               checks = 0;
   int               errors = 0;
   int               cyc = 0;
   int               n_out = 0;
   bit               lat_mode = 0;
   bit               xfer_in;
   bit               last_in_ready;
   bit               prev_stall = 0;
   logic [OUT_W-1:0] prev_d, last_d;
   logic             prev_sat, prev_nan, last_sat, last_nan;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Reference: exact real value scaled by 2^FRAC_W, rounded, then clipped.
   function automatic exp_t model(input logic [31:0] f);
      exp_t r;
      int   e;
      real  a, fl, fr, rd;
      bit   odd;
      r.d = '0; r.sat = 1'b0; r.nan = 1'b0; r.cyc = 0;
      e = int'(f[30:23]);
      if (e == 255) begin
         if (f[22:0] != 23'd0) r.nan = 1'b1;
         else begin r.sat = 1'b1; r.d = f[31] ? MINV : MAXV; end
         return r;
      end
      if (e == 0) return r;
      a  = (1.0 + real'(f[22:0]) / 8388608.0) * (2.0 ** (e - 127 + FRAC_W));
      fl = $floor(a);
      fr = a - fl;
      odd = (fl < 1.0e9) && (($rtoi(fl) % 2) == 1);
`ifdef FP2FIX_RNE_EN
      rd = (fr > 0.5 || (fr == 0.5 && odd)) ? fl + 1.0 : fl;
`else
      rd = (fr >= 0.5) ? fl + 1.0 : fl;
      if (odd && fr < 0.0) rd = fl;
`endif
      if (!f[31]) begin
         if (rd > real'(2 ** (OUT_W - 1) - 1)) begin r.sat = 1'b1; r.d = MAXV; end
         else r.d = OUT_W'($rtoi(rd));
      end else begin
         if (rd > real'(2 ** (OUT_W - 1))) begin r.sat = 1'b1; r.d = MINV; end
         else r.d = OUT_W'(-$rtoi(rd));
      end
      return r;
   endfunction

   // One clock cycle: inputs already driven at the falling edge; observe, then advance.
   task automatic tick();
      exp_t e;
      #1;
      xfer_in       = 0;
      last_in_ready = in_ready;
      if (rst) begin
         exp_q.delete();
         prev_stall = 0;
      end else begin
         check("in_ready_rule", in_ready, !out_valid || out_ready);
         if (prev_stall) begin
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, prev_d);
            check("hold_sat", out_sat, prev_sat);
            check("hold_nan", out_nan, prev_nan);
         end
         if (out_valid && out_ready) begin
            check("out_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("out_data", out_data, e.d);
               check("out_sat", out_sat, e.sat);
               check("out_nan", out_nan, e.nan);
               if (lat_mode) check("latency", cyc - e.cyc, 3);
               last_d = out_data; last_sat = out_sat; last_nan = out_nan;
               n_out++;
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_d = out_data; prev_sat = out_sat; prev_nan = out_nan;
         if (in_valid && in_ready) begin
            e = model(in_data);
            e.cyc = cyc;
            exp_q.push_back(e);
            xfer_in = 1;
         end
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic run_one(input string tag, input logic [31:0] f,
                          input logic [OUT_W-1:0] d, input logic sat, input logic nan);
      int n0;
      lat_mode = 1; out_ready = 1; in_valid = 1; in_data = f;
      n0 = n_out;
      tick();
      in_valid = 0;
      repeat (4) tick();
      check({tag, "_count"}, n_out - n0, 1);
      check({tag, "_data"}, last_d, d);
      check({tag, "_sat"}, last_sat, sat);
      check({tag, "_nan"}, last_nan, nan);
      lat_mode = 0;
   endtask

   function automatic logic [31:0] rand_float();
      logic [31:0] f;
      case ($urandom_range(0, 9))
         0: f = $urandom;
         1: f = {1'($urandom), 8'hFF, 23'($urandom_range(0, 1) ? $urandom : 0)};
         2: f = {1'($urandom), 8'h00, 23'($urandom)};
         3: f = {1'($urandom), 8'($urandom_range(110, 140)), 23'($urandom) & 23'h7F8000};
         default: f = {1'($urandom), 8'($urandom_range(105, 145)), 23'($urandom)};
      endcase
      return f;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] vals[5];
      int          idx, n0;
      bit          stall_seen, pending;

      rst = 1; in_valid = 0; in_data = '0; out_ready = 0;
      @(negedge clk);
      tick(); tick();
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_sat", out_sat, 0);
      check("rst_out_nan", out_nan, 0);
      check("rst_in_ready", in_ready, 1);
      rst = 0;
      tick();

      // directed corner values
      run_one("p1_5",   32'h3FC00000, 16'h0180, 0, 0);
      run_one("m2_25",  32'hC0100000, 16'hFDC0, 0, 0);
      run_one("p1000",  32'h447A0000, 16'h7FFF, 1, 0);
      run_one("m128",   32'hC3000000, 16'h8000, 0, 0);
      run_one("minf",   32'hFF800000, 16'h8000, 1, 0);
      run_one("pinf",   32'h7F800000, 16'h7FFF, 1, 0);
`ifdef FP2FIX_RNE_EN
      run_one("tie_p",  32'h3B000000, 16'h0000, 0, 0);
      run_one("tie_m",  32'hBB000000, 16'h0000, 0, 0);
`else
      run_one("tie_p",  32'h3B000000, 16'h0001, 0, 0);
      run_one("tie_m",  32'hBB000000, 16'hFFFF, 0, 0);
`endif
      run_one("above_tie", 32'h3B400000, 16'h0001, 0, 0);
      run_one("nan",    32'h7FC00000, 16'h0000, 0, 1);
      run_one("mzero",  32'h80000000, 16'h0000, 0, 0);

      // backpressure: 5 back-to-back, out_ready low for cycles 2..5
      for (int i = 0; i < 5; i++) vals[i] = {1'($urandom), 8'($urandom_range(120, 133)), 23'($urandom)};
      idx = 0; n0 = n_out; stall_seen = 0;
      for (int c = 0; c < 20; c++) begin
         out_ready = !(c >= 2 && c < 6);
         in_valid  = (idx < 5);
         in_data   = vals[(idx < 5) ? idx : 0];
         tick();
         if (xfer_in) idx++;
         if (!last_in_ready) stall_seen = 1;
      end
      in_valid = 0;
      check("bp_count", n_out - n0, 5);
      check("bp_in_ready_dropped", stall_seen, 1);
      check("bp_queue_empty", exp_q.size(), 0);

      // reset with three items in flight
      out_ready = 1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1; in_data = rand_float();
         tick();
      end
      rst = 1; in_valid = 1; in_data = 32'h3FC00000;
      tick();
      rst = 0; in_valid = 0;
      #1;
      check("rst_mid_valid", out_valid, 0);
      n0 = n_out;
      repeat (5) tick();
      check("rst_no_stale", n_out - n0, 0);
      run_one("post_rst", 32'h40000000, 16'h0200, 0, 0);

      // randomized traffic with random backpressure; upstream holds data while stalled
      pending = 0;
      for (int c = 0; c < 3000; c++) begin
         if (!pending) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = rand_float();
         end
         out_ready = ($urandom_range(0, 3) != 0);
         tick();
         pending = in_valid && !xfer_in;
      end
      in_valid = 0; out_ready = 1;
      repeat (6) tick();
      check("drain_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fp2fix_conv.md
Name: fp2fix_conv

Overview:
- 3-stage pipelined converter from IEEE-754 single-precision floats (add/sub datapath output format) to signed fixed-point samples.
- Sits at the output end of the butterfly FFT datapath, feeding fixed-point consumers.
- Valid/ready handshake on both sides; saturation and NaN flags travel with each result.

Parameters:
- OUT_W, 16, total width of the signed two's-complement output; legal range 8..32.
- FRAC_W, 8, fractional bits of the output; must satisfy 0 <= FRAC_W < OUT_W.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  32  IEEE-754 single: sign [31], exponent [30:23], mantissa [22:0].
- in_valid  in  1  in_data valid.
- in_ready  out  1  converter accepts in_data this cycle.
- out_data  out  OUT_W  signed fixed-point result.
- out_valid  out  1  out_data, out_sat and out_nan valid.
- out_ready  in  1  downstream accepts the result.
- out_sat  out  1  result was clipped to OUT_W range (includes +/-Inf).
- out_nan  out  1  input was NaN; out_data is 0.

Behaviour:
- Reset: every stage valid bit cleared; out_valid=0, out_data=0, out_sat=0, out_nan=0. in_ready follows the advance rule below.
- Reset mid-operation: all in-flight items are discarded with no output. Any transfer presented in the reset cycle is not captured.
- Advance rule: adv = !out_valid || out_ready; in_ready = adv.
  - All three stages shift together when adv=1.
  - When adv=0 every stage register holds.
  - Bubbles are not collapsed.
- Input transfer: in_valid && in_ready. Output transfer: out_valid && out_ready.
- Latency: 3 cycles from input transfer to out_valid with no backpressure. Throughput: 1 per cycle.
- Output stability: while out_valid=1 && out_ready=0, out_data, out_sat and out_nan are held stable.
- Stage 1 (unpack):
  - Latch sign s, exponent e, and significand {1, mantissa} (24b).
  - Classify: zero/denormal (e=0), Inf (e=255, mant=0), NaN (e=255, mant!=0).
  - Compute signed shift k = e - 127 + FRAC_W - 23 (10-bit signed).
- Stage 2 (shift):
  - k >= 0: left shift of the significand into a wide magnitude register. Overflow detection is exact for any k: any 1 shifted beyond bit OUT_W-1 marks overflow.
  - k < 0: right shift by -k. Keep a guard bit and a sticky bit. k < -25 yields magnitude 0 with guard=0.
- Stage 3 (round/saturate/sign):
  - Round to nearest, ties away from zero: magnitude += guard. The sticky bit is not needed for this mode but is kept for the optional rounding mode.
  - Apply sign by two's-complement negation.
  - Saturation: positive magnitude > 2^(OUT_W-1)-1 gives 2^(OUT_W-1)-1, out_sat=1. Negative magnitude > 2^(OUT_W-1) gives -2^(OUT_W-1), out_sat=1.
  - Exact -2^(OUT_W-1) is representable and gives out_sat=0.
  - Rounding carry that pushes past range also saturates.
- Special inputs:
  - Zero/denormal: out_data=0, flags 0. Sign is ignored, so -0 gives 0.
  - +Inf gives max positive, out_sat=1. -Inf gives min negative, out_sat=1.
  - NaN gives out_data=0, out_nan=1, out_sat=0.
- No internal FIFO; the upstream must hold in_data while in_ready=0.

Optional Feature:
- Macro: FP2FIX_RNE_EN.
- Defined: rounding becomes round-to-nearest, ties-to-even.
  - Increment when guard && (sticky || lsb).
  - Saturation and flag rules are unchanged.
- Undefined: ties-away-from-zero as above. Sticky logic may be optimised away.
- Latency and ports are identical in both builds.

Test Plan:
- OUT_W=16, FRAC_W=8, out_ready=1:
  - 0x3FC00000 (1.5) -> 0x0180 after exactly 3 cycles, flags 0.
  - 0xC0100000 (-2.25) -> 0xFDC0.
- Range limits:
  - 0x447A0000 (1000.0) -> 0x7FFF, out_sat=1.
  - 0xC3000000 (-128.0) -> 0x8000, out_sat=0.
  - 0xFF800000 (-Inf) -> 0x8000, out_sat=1.
- Rounding:
  - 0x3B000000 (2^-9) -> 0x0001 by default, 0x0000 with FP2FIX_RNE_EN.
  - 0xBB000000 -> 0xFFFF by default, 0x0000 with FP2FIX_RNE_EN.
  - 0x3B400000 (1.5*2^-9) -> 0x0001 in both builds.
- Specials: 0x7FC00000 -> 0x0000, out_nan=1. 0x80000000 -> 0x0000, flags 0.
- Backpressure:
  - Stream 5 values back-to-back with out_ready=0 from cycle 2 for 4 cycles.
  - in_ready drops once out_valid=1 and out_ready=0.
  - out_data stays stable throughout the stall.
  - All 5 results emerge in order, with no loss or duplication.
- Reset: assert rst for 1 cycle with 3 items in flight -> out_valid=0 the next cycle and no stale outputs afterwards. A new input appears 3 cycles after its transfer.
